// File: rtl/hamming15_enc_scheduler.sv
// Round-robin scheduler sharing one Hamming(15,11) encoder among N_REQ requesters.
// Registers the encoder input/ir control and tags each codeword with its requester.
module hamming15_enc_scheduler #(
  parameter int unsigned  N_REQ       = 4,
  parameter int unsigned  BURST_MAX   = 8,
  parameter int unsigned  ENC_LATENCY = 1,
  parameter logic [3:0]   IR_INIT     = 4'b0110,
  localparam int unsigned ID_W        = $clog2(N_REQ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*11-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                ir_step_en,
  output logic [10:0]         enc_in,
  output logic [3:0]          enc_ir,
  input  logic [14:0]         enc_out,
  output logic                out_valid,
  output logic [14:0]         out_data,
  output logic [ID_W-1:0]     out_id,
  output logic                busy
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]                      state_q, state_d;
  logic [ID_W-1:0]                 gnt_q, gnt_d;
  logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [7:0]                      burst_cnt_q, burst_cnt_d;
  logic [10:0]                     enc_in_q, enc_in_d;
  logic [3:0]                      enc_ir_q, enc_ir_d;
  logic [ENC_LATENCY:0]            tag_valid_q, tag_valid_d;
  logic [ENC_LATENCY:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic                            out_valid_q;
  logic [ID_W-1:0]                 out_id_q;

  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;
  logic [10:0]     gnt_word;
  logic            in_grant;
  logic            accept;
  logic            burst_last;

  // Search starts just after the last served requester so it goes to the back of the line.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % N_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    gnt_word = '0;
    for (int unsigned r = 0; r < N_REQ; r++) begin
      if (gnt_q == ID_W'(r)) gnt_word = req_data[r*11 +: 11];
    end
  end

  assign in_grant   = (state_q == StGrant);
  assign accept     = in_grant && req_valid[gnt_q];
  assign burst_last = ((32'(burst_cnt_q) + 32'd1) == BURST_MAX);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready = N_REQ'(1) << gnt_q;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    enc_in_d    = enc_in_q;
    enc_ir_d    = enc_ir_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d     = StGrant;
          gnt_d       = pick_id;
          burst_cnt_d = '0;
        end
      end
      default: begin
        if (accept) begin
          enc_in_d    = gnt_word;
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (ir_step_en) enc_ir_d = enc_ir_q + 4'd1;
        end
        if (!req_valid[gnt_q] || (accept && burst_last)) begin
          state_d  = StIdle;
          rr_ptr_d = gnt_q;
        end
      end
    endcase
  end

  // Tag pipeline tracks encoder latency; idle slots carry id 0.
  always_comb begin
    tag_valid_d = {tag_valid_q[ENC_LATENCY-1:0], accept};
    tag_id_d    = tag_id_q;
    tag_id_d[0] = accept ? gnt_q : '0;
    for (int unsigned k = 1; k <= ENC_LATENCY; k++) begin
      tag_id_d[k] = tag_id_q[k-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      burst_cnt_q <= '0;
      enc_in_q    <= '0;
      enc_ir_q    <= IR_INIT;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      enc_in_q    <= enc_in_d;
      enc_ir_q    <= enc_ir_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      out_valid_q <= tag_valid_q[ENC_LATENCY];
      out_id_q    <= tag_id_q[ENC_LATENCY];
    end
  end

  assign enc_in    = enc_in_q;
  assign enc_ir    = enc_ir_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = enc_out;
  assign busy      = in_grant | (|tag_valid_q) | out_valid_q;

endmodule

// File: tb/tb_hamming15_enc_scheduler.sv
// Directed bench for hamming15_enc_scheduler: two instances (encoder latency 1 and 3)
// share stimulus; each has a behavioural encoder model aligned to the tag pipeline.
module tb_hamming15_enc_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [43:0] req_data;
  logic        ir_step_en;

  logic [3:0]  req_ready1, req_ready3;
  logic [10:0] enc_in1, enc_in3;
  logic [3:0]  enc_ir1, enc_ir3;
  logic [14:0] enc_out1, enc_out3;
  logic        out_valid1, out_valid3;
  logic [14:0] out_data1, out_data3;
  logic [1:0]  out_id1, out_id3;
  logic        busy1, busy3;

  int checks = 0;
  int errors = 0;

  hamming15_enc_scheduler #(.N_REQ(4), .BURST_MAX(8), .ENC_LATENCY(1), .IR_INIT(4'b0110)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready1), .ir_step_en(ir_step_en), .enc_in(enc_in1), .enc_ir(enc_ir1),
    .enc_out(enc_out1), .out_valid(out_valid1), .out_data(out_data1), .out_id(out_id1),
    .busy(busy1)
  );

  hamming15_enc_scheduler #(.N_REQ(4), .BURST_MAX(8), .ENC_LATENCY(3), .IR_INIT(4'b0110)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready3), .ir_step_en(ir_step_en), .enc_in(enc_in3), .enc_ir(enc_ir3),
    .enc_out(enc_out3), .out_valid(out_valid3), .out_data(out_data3), .out_id(out_id3),
    .busy(busy3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [14:0] ham(input logic [10:0] d);
    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [14:0] c = '0;
    logic par;
    for (int k = 0; k < 11; k++) c[pos[k]-1] = d[k];
    for (int p = 0; p < 4; p++) begin
      par = 1'b0;
      for (int j = 1; j < 16; j++) if ((j & (1 << p)) != 0) par ^= c[j-1];
      c[(1 << p) - 1] = par;
    end
    return c;
  endfunction

  // Encoder models: codeword appears ENC_LATENCY+1 edges after enc_in updates.
  logic [14:0] e1 [2];
  logic [14:0] e3 [4];
  always @(posedge clock) begin
    e1[0] <= ham(enc_in1);
    e1[1] <= e1[0];
    e3[0] <= ham(enc_in3);
    for (int k = 1; k < 4; k++) e3[k] <= e3[k-1];
  end
  assign enc_out1 = e1[1];
  assign enc_out3 = e3[3];

  function automatic int oh_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b0;
    req_valid = '0;
    tick();
    reset = 1'b1;
  endtask

  int n, m, bub, seq_bad, oid_bad, last_id, g;
  logic wrapped;
  logic [3:0] prev_ir, prev_rdy;
  int gs [4];

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; ir_step_en = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid1), 0);
    check("rst_out_id", 32'(out_id1), 0);
    check("rst_req_ready", 32'(req_ready1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_enc_in", 32'(enc_in1), 0);
    check("rst_enc_ir", 32'(enc_ir1), 32'h6);
    reset = 1'b1;

    // Three-word burst from requester 0 with ir stepping
    req_data[10:0] = 11'h001; req_valid = 4'b0001; ir_step_en = 1'b1;
    tick();
    check("t1_ready", 32'(req_ready1), 32'h1);
    check("t1_busy", 32'(busy1), 1);
    tick();
    check("t1_enc_in", 32'(enc_in1), 32'h001);
    check("t1_ir0", 32'(enc_ir1), 32'h7);
    req_data[10:0] = 11'h002;
    tick();
    check("t1_ir1", 32'(enc_ir1), 32'h8);
    check("t1_early_valid", 32'(out_valid1), 0);
    req_data[10:0] = 11'h003;
    tick();
    check("t1_ir2", 32'(enc_ir1), 32'h9);
    check("t1_v0", 32'(out_valid1), 1);
    check("t1_id0", 32'(out_id1), 0);
    check("t1_cw0", 32'(out_data1), 32'h0007);
    check("t1_l3_early", 32'(out_valid3), 0);
    req_valid = 4'b0000;
    tick();
    check("t1_v1", 32'(out_valid1), 1);
    check("t1_cw1", 32'(out_data1), 32'h0019);
    check("t1_ready_off", 32'(req_ready1), 0);
    tick();
    check("t1_cw2", 32'(out_data1), 32'h001E);
    check("t1_l3_v0", 32'(out_valid3), 1);
    check("t1_l3_cw0", 32'(out_data3), 32'h0007);
    tick();
    check("t1_v_end", 32'(out_valid1), 0);
    check("t1_l3_cw1", 32'(out_data3), 32'h0019);
    tick();
    check("t1_l3_cw2", 32'(out_data3), 32'h001E);
    tick();
    check("t1_l3_v_end", 32'(out_valid3), 0);
    check("t1_busy1_end", 32'(busy1), 0);
    check("t1_busy3_end", 32'(busy3), 0);

    // enc_ir wrap over 15 stepped accepts, then hold with stepping off
    do_reset();
    req_data[10:0] = 11'h005; req_valid = 4'b0001; ir_step_en = 1'b1;
    n = 0; wrapped = 1'b0;
    for (int c = 0; c < 60 && n < 15; c++) begin
      if (req_ready1[0]) n++;
      prev_ir = enc_ir1;
      tick();
      if (prev_ir == 4'hF && enc_ir1 == 4'h0) wrapped = 1'b1;
    end
    check("ir_accepts", 32'(n), 15);
    check("ir_after15", 32'(enc_ir1), 32'h5);
    check("ir_wrapped", 32'(wrapped), 1);
    ir_step_en = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      if (req_ready1[0]) n++;
      tick();
    end
    check("ir_hold", 32'(enc_ir1), 32'h5);

    // All four requesters continuously valid: bursts of 8 in order 0,1,2,3,0
    do_reset();
    for (int r = 0; r < 4; r++) req_data[r*11 +: 11] = 11'(11'h100 + r);
    req_valid = 4'b1111; ir_step_en = 1'b0;
    n = 0; m = 0; bub = 0; seq_bad = 0; oid_bad = 0; last_id = -1;
    for (int c = 0; c < 80 && n < 33; c++) begin
      if (req_ready1 != 4'b0000) begin
        if (n < 32) begin
          if (oh_idx(req_ready1) != n / 8) seq_bad++;
        end else begin
          last_id = oh_idx(req_ready1);
        end
        n++;
      end else if (n > 0) begin
        bub++;
      end
      if (out_valid1) begin
        if (m < 32 && int'(out_id1) != m / 8) oid_bad++;
        m++;
      end
      tick();
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      if (out_valid1) begin
        if (m < 32 && int'(out_id1) != m / 8) oid_bad++;
        m++;
      end
      tick();
    end
    check("rr_accepts", 32'(n), 33);
    check("rr_seq_bad", 32'(seq_bad), 0);
    check("rr_wrap_to_0", 32'(last_id), 0);
    check("rr_bubbles", 32'(bub), 4);
    check("rr_out_count", 32'(m), 33);
    check("rr_out_id_bad", 32'(oid_bad), 0);
    check("rr_ir_const", 32'(enc_ir1), 32'h6);

    // Async reset mid-burst of requester 1 with two tags in flight
    do_reset();
    req_data[10:0] = 11'h0AA; req_data[21:11] = 11'h055;
    req_valid = 4'b0001; ir_step_en = 1'b1;
    tick();
    tick();
    req_valid = 4'b0010;
    tick();
    tick();
    check("ar_grant1", 32'(req_ready1), 32'h2);
    tick();
    tick();
    check("ar_pre_busy", 32'(busy1), 1);
    check("ar_pre_enc_in", 32'(enc_in1), 32'h055);
    check("ar_pre_ir", 32'(enc_ir1), 32'h9);
    check("ar_pre_valid", 32'(out_valid1), 0);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid1), 0);
    check("ar_busy", 32'(busy1), 0);
    check("ar_busy3", 32'(busy3), 0);
    check("ar_ready", 32'(req_ready1), 0);
    check("ar_enc_in", 32'(enc_in1), 0);
    check("ar_enc_ir", 32'(enc_ir1), 32'h6);
    req_valid = 4'b1111;
    #1;
    reset = 1'b1;
    tick();
    check("ar_next_grant", 32'(req_ready1), 32'h1);
    check("ar_no_out0", 32'(out_valid1), 0);
    tick();
    check("ar_no_out1", 32'(out_valid1), 0);
    tick();
    check("ar_no_out2", 32'(out_valid1), 0);
    tick();
    check("ar_first_out", 32'(out_valid1), 1);

    // Requester 2 drops valid mid-burst: it goes to the back of the round
    do_reset();
    req_valid = 4'b1111; ir_step_en = 1'b0;
    for (int c = 0; c < 40 && req_ready1 != 4'b0100; c++) tick();
    check("dr_reach2", 32'(req_ready1), 32'h4);
    tick();
    tick();
    req_valid = 4'b1011;
    tick();
    check("dr_left", 32'(req_ready1), 0);
    req_valid = 4'b1111;
    g = 0; prev_rdy = 4'b0000;
    for (int k = 0; k < 4; k++) gs[k] = -1;
    for (int c = 0; c < 80 && g < 4; c++) begin
      if (req_ready1 != 4'b0000 && prev_rdy == 4'b0000) begin
        gs[g] = oh_idx(req_ready1);
        g++;
      end
      prev_rdy = req_ready1;
      tick();
    end
    check("dr_g0", 32'(gs[0]), 3);
    check("dr_g1", 32'(gs[1]), 0);
    check("dr_g2", 32'(gs[2]), 1);
    check("dr_g3", 32'(gs[3]), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
